// File: rtl/rx_udp_if.sv
// Segment byte stream into the UDP stage and the header/payload stream out of it.
// The master side is the rx_udp block; the slave side is whatever feeds and consumes it.
interface rx_udp_if #(
   parameter int OCT = 8
);
   logic           rx_data_udp;
   logic [OCT-1:0] rx_data;
   logic [15:0]    rx_src_port;
   logic [15:0]    rx_dst_port;
   logic [15:0]    rx_udp_len;
   logic           rx_hdr_valid;
   logic           rx_udp_valid;
   logic [OCT-1:0] rx_udp_data;
   logic           rx_udp_sop;
   logic           rx_udp_eop;
   logic           rx_udp_err;

   modport master (
      input  rx_data_udp,
      input  rx_data,
      output rx_src_port,
      output rx_dst_port,
      output rx_udp_len,
      output rx_hdr_valid,
      output rx_udp_valid,
      output rx_udp_data,
      output rx_udp_sop,
      output rx_udp_eop,
      output rx_udp_err
   );

   modport slave (
      output rx_data_udp,
      output rx_data,
      input  rx_src_port,
      input  rx_dst_port,
      input  rx_udp_len,
      input  rx_hdr_valid,
      input  rx_udp_valid,
      input  rx_udp_data,
      input  rx_udp_sop,
      input  rx_udp_eop,
      input  rx_udp_err
   );
endinterface

// File: rtl/rx_udp.sv
// UDP receive stage: parses the 8-byte header, filters on destination port and
// forwards exactly udp_len-8 payload bytes with sop/eop framing.
module rx_udp #(
   parameter int          OCT        = 8,
   parameter logic [15:0] LOCAL_PORT = 16'd0
) (
   input logic      RX_CLK,
   input logic      rst,
   rx_udp_if.master u
);
   typedef enum logic [2:0] {
      SRC_PORT,
      DST_PORT,
      LEN,
      CSUM,
      DATA,
      DROP
   } state_t;

   state_t         state_reg;
   logic           byte_sel_reg;
   logic           prev_valid_reg;
   logic           first_reg;
   logic [15:0]    src_port_reg;
   logic [15:0]    dst_port_reg;
   logic [15:0]    udp_len_reg;
   logic [15:0]    remaining_reg;
   logic           hdr_valid_reg;
   logic           udp_valid_reg;
   logic [OCT-1:0] udp_data_reg;
   logic           sop_reg;
   logic           eop_reg;
   logic           err_reg;

   logic           seg_open;
   logic           stray_bytes;

   // A segment counts as open once its first header byte has been consumed and
   // until its payload is complete; losing rx_data_udp then means truncation.
   assign seg_open = (state_reg == DST_PORT) || (state_reg == LEN) ||
                     (state_reg == CSUM) || (state_reg == DATA) ||
                     ((state_reg == SRC_PORT) && byte_sel_reg);

   // Bytes arriving at SRC_PORT with no preceding low cycle are the tail of a
   // segment interrupted by reset; they must not be parsed as a header.
   assign stray_bytes = (state_reg == SRC_PORT) && !byte_sel_reg && prev_valid_reg;

   always_ff @(posedge RX_CLK) begin
      if (rst) begin
         state_reg      <= SRC_PORT;
         byte_sel_reg   <= 1'b0;
         prev_valid_reg <= u.rx_data_udp;
         first_reg      <= 1'b0;
         src_port_reg   <= 16'd0;
         dst_port_reg   <= 16'd0;
         udp_len_reg    <= 16'd0;
         remaining_reg  <= 16'd0;
         hdr_valid_reg  <= 1'b0;
         udp_valid_reg  <= 1'b0;
         udp_data_reg   <= '0;
         sop_reg        <= 1'b0;
         eop_reg        <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         prev_valid_reg <= u.rx_data_udp;
         hdr_valid_reg  <= 1'b0;
         udp_valid_reg  <= 1'b0;
         sop_reg        <= 1'b0;
         eop_reg        <= 1'b0;
         err_reg        <= 1'b0;

         if (!u.rx_data_udp) begin
            if (prev_valid_reg) begin
               if (seg_open) begin
                  err_reg <= 1'b1;
               end
               state_reg     <= SRC_PORT;
               byte_sel_reg  <= 1'b0;
               remaining_reg <= 16'd0;
               first_reg     <= 1'b0;
            end
         end else if (stray_bytes) begin
            state_reg <= DROP;
         end else begin
            case (state_reg)
               SRC_PORT: begin
                  src_port_reg <= {src_port_reg[15-OCT:0], u.rx_data};
                  byte_sel_reg <= ~byte_sel_reg;
                  if (byte_sel_reg) begin
                     state_reg <= DST_PORT;
                  end
               end
               DST_PORT: begin
                  dst_port_reg <= {dst_port_reg[15-OCT:0], u.rx_data};
                  byte_sel_reg <= ~byte_sel_reg;
                  if (byte_sel_reg) begin
                     state_reg <= LEN;
                  end
               end
               LEN: begin
                  udp_len_reg  <= {udp_len_reg[15-OCT:0], u.rx_data};
                  byte_sel_reg <= ~byte_sel_reg;
                  if (byte_sel_reg) begin
                     state_reg <= CSUM;
                  end
               end
               CSUM: begin
                  // Checksum bytes are consumed but not verified.
                  byte_sel_reg <= ~byte_sel_reg;
                  if (byte_sel_reg) begin
                     remaining_reg <= udp_len_reg - 16'd8;
                     if (udp_len_reg < 16'd8) begin
                        err_reg   <= 1'b1;
                        state_reg <= DROP;
                     end else if ((LOCAL_PORT != 16'd0) && (dst_port_reg != LOCAL_PORT)) begin
                        state_reg <= DROP;
                     end else begin
                        hdr_valid_reg <= 1'b1;
                        first_reg     <= 1'b1;
                        state_reg     <= (udp_len_reg == 16'd8) ? DROP : DATA;
                     end
                  end
               end
               DATA: begin
                  udp_valid_reg <= 1'b1;
                  udp_data_reg  <= u.rx_data;
                  sop_reg       <= first_reg;
                  first_reg     <= 1'b0;
                  eop_reg       <= (remaining_reg == 16'd1);
                  remaining_reg <= remaining_reg - 16'd1;
                  if (remaining_reg == 16'd1) begin
                     state_reg <= DROP;
                  end
               end
               default: begin
                  // DROP: padding or filtered bytes until rx_data_udp goes low.
                  state_reg <= DROP;
               end
            endcase
         end
      end
   end

   assign u.rx_src_port  = src_port_reg;
   assign u.rx_dst_port  = dst_port_reg;
   assign u.rx_udp_len   = udp_len_reg;
   assign u.rx_hdr_valid = hdr_valid_reg;
   assign u.rx_udp_valid = udp_valid_reg;
   assign u.rx_udp_data  = udp_data_reg;
   assign u.rx_udp_sop   = sop_reg;
   assign u.rx_udp_eop   = eop_reg;
   assign u.rx_udp_err   = err_reg;
endmodule

// File: tb/tb_rx_udp.sv
// Bench for rx_udp: two instances (accept-any and port-5000 filter) share one input
// stream; a segment-level model predicts every output cycle.
module tb_rx_udp;
   localparam int          NCYC = 4096;
   localparam logic [15:0] LP0  = 16'd0;
   localparam logic [15:0] LP1  = 16'd5000;

   logic       RX_CLK = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   int         cyc = 0;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int hdr_cnt[2];
   int err_cnt[2];
   logic [9:0] cap0[$];
   logic [7:0] seg[$];

   bit        exp_hdr  [2][NCYC];
   bit        exp_valid[2][NCYC];
   bit        exp_sop  [2][NCYC];
   bit        exp_eop  [2][NCYC];
   bit        exp_err  [2][NCYC];
   bit [7:0]  exp_data [2][NCYC];
   bit [15:0] exp_src  [2][NCYC];
   bit [15:0] exp_dst  [2][NCYC];
   bit [15:0] exp_len  [2][NCYC];

   always #5 RX_CLK = ~RX_CLK;
   always @(posedge RX_CLK) cyc <= cyc + 1;

   rx_udp_if #(.OCT(8)) if0 ();
   rx_udp_if #(.OCT(8)) if1 ();

   assign if0.rx_data_udp = in_valid;
   assign if0.rx_data     = in_data;
   assign if1.rx_data_udp = in_valid;
   assign if1.rx_data     = in_data;

   rx_udp #(.OCT(8), .LOCAL_PORT(LP0)) dut0 (.RX_CLK(RX_CLK), .rst(rst), .u(if0.master));
   rx_udp #(.OCT(8), .LOCAL_PORT(LP1)) dut1 (.RX_CLK(RX_CLK), .rst(rst), .u(if1.master));

   task automatic chk(input string name, input int d, input logic [15:0] act, input logic [15:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s dut%0d cyc=%0d: got %h, expected %h", name, d, cyc, act, req);
   endtask

   task automatic cmp(input int d, input logic hv, input logic v, input logic so, input logic eo,
                      input logic er, input logic [7:0] dat, input logic [15:0] sp,
                      input logic [15:0] dp, input logic [15:0] ln);
      chk("hdr_valid", d, {15'd0, hv}, {15'd0, exp_hdr[d][cyc]});
      chk("udp_valid", d, {15'd0, v},  {15'd0, exp_valid[d][cyc]});
      chk("sop",       d, {15'd0, so}, {15'd0, exp_sop[d][cyc]});
      chk("eop",       d, {15'd0, eo}, {15'd0, exp_eop[d][cyc]});
      chk("err",       d, {15'd0, er}, {15'd0, exp_err[d][cyc]});
      if (exp_valid[d][cyc]) chk("data", d, {8'd0, dat}, {8'd0, exp_data[d][cyc]});
      if (exp_hdr[d][cyc]) begin
         chk("src_port", d, sp, exp_src[d][cyc]);
         chk("dst_port", d, dp, exp_dst[d][cyc]);
         chk("udp_len",  d, ln, exp_len[d][cyc]);
      end
      if (v === 1'b1 && d == 0) cap0.push_back({so, eo, dat});
      if (hv === 1'b1) hdr_cnt[d]++;
      if (er === 1'b1) err_cnt[d]++;
   endtask

   always @(negedge RX_CLK) begin
      if (cyc >= 1 && cyc < NCYC) begin
         cmp(0, if0.rx_hdr_valid, if0.rx_udp_valid, if0.rx_udp_sop, if0.rx_udp_eop, if0.rx_udp_err,
             if0.rx_udp_data, if0.rx_src_port, if0.rx_dst_port, if0.rx_udp_len);
         cmp(1, if1.rx_hdr_valid, if1.rx_udp_valid, if1.rx_udp_sop, if1.rx_udp_eop, if1.rx_udp_err,
             if1.rx_udp_data, if1.rx_src_port, if1.rx_dst_port, if1.rx_udp_len);
      end
   end

   // Segment-level prediction: s is the cycle the first byte is driven; an input
   // byte driven at cycle c shows its effect at cycle c+1.
   task automatic model(input int s, input int n_sent, input int rst_at);
      int          lim;
      int          pl;
      logic [15:0] src, dst, len, lp;
      src = {seg[0], seg[1]};
      dst = {seg[2], seg[3]};
      len = {seg[4], seg[5]};
      lim = (rst_at >= 0) ? rst_at : n_sent;
      for (int d = 0; d < 2; d++) begin
         lp = (d == 0) ? LP0 : LP1;
         if (lim < 8) begin
            if (rst_at < 0 && n_sent > 0) exp_err[d][s + n_sent + 1] = 1'b1;
            continue;
         end
         if (len < 16'd8) begin
            exp_err[d][s + 8] = 1'b1;
            continue;
         end
         if (lp != 16'd0 && dst != lp) continue;
         exp_hdr[d][s + 8] = 1'b1;
         exp_src[d][s + 8] = src;
         exp_dst[d][s + 8] = dst;
         exp_len[d][s + 8] = len;
         pl = int'(len) - 8;
         for (int k = 0; k < pl && 8 + k < lim; k++) begin
            exp_valid[d][s + 9 + k] = 1'b1;
            exp_data[d][s + 9 + k]  = seg[8 + k];
            exp_sop[d][s + 9 + k]   = (k == 0);
            exp_eop[d][s + 9 + k]   = (k == pl - 1);
         end
         if (rst_at < 0 && n_sent < 8 + pl) exp_err[d][s + n_sent + 1] = 1'b1;
      end
   endtask

   task automatic send(input int n_sent, input int rst_at, input int gap);
      int s;
      @(negedge RX_CLK);
      s = cyc;
      model(s, n_sent, rst_at);
      for (int i = 0; i < n_sent; i++) begin
         if (i > 0) @(negedge RX_CLK);
         in_valid = 1'b1;
         in_data  = seg[i];
         rst      = (i == rst_at);
      end
      @(negedge RX_CLK);
      in_valid = 1'b0;
      in_data  = 8'h00;
      rst      = 1'b0;
      repeat (gap) @(negedge RX_CLK);
      #1;
   endtask

   task automatic chk_cap(input string name, input int idx, input logic [9:0] req);
      chk(name, 0, (idx < cap0.size()) ? {6'd0, cap0[idx]} : 16'hFFFF, {6'd0, req});
   endtask

   initial begin
      int h0, h1, e0, e1;
      hdr_cnt = '{0, 0};
      err_cnt = '{0, 0};
      in_valid = 1'b0;
      in_data  = 8'h00;
      rst      = 1'b1;
      repeat (3) @(negedge RX_CLK);
      chk("rst_src",   0, if0.rx_src_port, 16'h0000);
      chk("rst_dst",   0, if0.rx_dst_port, 16'h0000);
      chk("rst_len",   1, if1.rx_udp_len,  16'h0000);
      chk("rst_valid", 0, {15'd0, if0.rx_udp_valid}, 16'h0000);
      rst = 1'b0;

      // 1: basic 4-byte payload, accepted only by the accept-any instance
      seg = {8'h04, 8'hD2, 8'h1F, 8'h90, 8'h00, 8'h0C, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      cap0.delete();
      send(seg.size(), -1, 3);
      chk("t1_count", 0, 16'(cap0.size()), 16'd4);
      chk_cap("t1_b0", 0, 10'h2DE);
      chk_cap("t1_b1", 1, 10'h0AD);
      chk_cap("t1_b2", 2, 10'h0BE);
      chk_cap("t1_b3", 3, 10'h1EF);
      chk("t1_src", 0, if0.rx_src_port, 16'd1234);
      chk("t1_dst", 0, if0.rx_dst_port, 16'd8080);
      chk("t1_len", 0, if0.rx_udp_len,  16'd12);
      chk("t1_filtered_hdr", 1, 16'(hdr_cnt[1]), 16'd0);

      // 2: same segment plus 6 bytes of padding
      seg = {8'h04, 8'hD2, 8'h1F, 8'h90, 8'h00, 8'h0C, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      cap0.delete();
      send(seg.size(), -1, 3);
      chk("t2_count", 0, 16'(cap0.size()), 16'd4);
      chk_cap("t2_b3", 3, 10'h1EF);

      // 3: dst 5000 passes both instances
      seg = {8'h11, 8'h11, 8'h13, 8'h88, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h12, 8'h34};
      send(seg.size(), -1, 3);
      chk("t3_dst1", 1, if1.rx_dst_port, 16'd5000);
      chk("t3_hdr1", 1, 16'(hdr_cnt[1]), 16'd1);

      // 4: empty payload
      seg = {8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h08, 8'h00, 8'h00};
      cap0.delete();
      h0 = hdr_cnt[0];
      send(seg.size(), -1, 3);
      chk("t4_hdr", 0, 16'(hdr_cnt[0] - h0), 16'd1);
      chk("t4_count", 0, 16'(cap0.size()), 16'd0);

      // 5: single-byte payload
      seg = {8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h09, 8'h00, 8'h00, 8'h55};
      cap0.delete();
      send(seg.size(), -1, 3);
      chk("t5_count", 0, 16'(cap0.size()), 16'd1);
      chk_cap("t5_b0", 0, 10'h355);

      // 6: len 20 but only 5 payload bytes arrive
      seg = {8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h14, 8'h00, 8'h00,
             8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      cap0.delete();
      e0 = err_cnt[0];
      e1 = err_cnt[1];
      send(seg.size(), -1, 3);
      chk("t6_count", 0, 16'(cap0.size()), 16'd5);
      chk_cap("t6_b4", 4, 10'h005);
      chk("t6_err0", 0, 16'(err_cnt[0] - e0), 16'd1);
      chk("t6_err1", 1, 16'(err_cnt[1] - e1), 16'd0);

      // 7: len below header size
      seg = {8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h00, 8'hAA, 8'hBB};
      h0 = hdr_cnt[0];
      e0 = err_cnt[0];
      e1 = err_cnt[1];
      send(seg.size(), -1, 3);
      chk("t7_err0", 0, 16'(err_cnt[0] - e0), 16'd1);
      chk("t7_err1", 1, 16'(err_cnt[1] - e1), 16'd1);
      chk("t7_hdr0", 0, 16'(hdr_cnt[0] - h0), 16'd0);

      // 8: truncated header
      seg = {8'h00, 8'h01, 8'h00};
      e0 = err_cnt[0];
      send(seg.size(), -1, 3);
      chk("t8_err0", 0, 16'(err_cnt[0] - e0), 16'd1);

      // 9: reset pulse in the middle of the payload, segment keeps streaming
      seg = {8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h10, 8'h00, 8'h00,
             8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
      cap0.delete();
      e0 = err_cnt[0];
      h1 = hdr_cnt[0];
      send(seg.size(), 10, 3);
      chk("t9_count", 0, 16'(cap0.size()), 16'd2);
      chk_cap("t9_b0", 0, 10'h2A0);
      chk_cap("t9_b1", 1, 10'h0A1);
      chk("t9_err0", 0, 16'(err_cnt[0] - e0), 16'd0);
      chk("t9_hdr0", 0, 16'(hdr_cnt[0] - h1), 16'd1);

      // 10: a clean segment after the reset
      seg = {8'h04, 8'hD2, 8'h1F, 8'h90, 8'h00, 8'h0C, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      cap0.delete();
      send(seg.size(), -1, 3);
      chk("t10_count", 0, 16'(cap0.size()), 16'd4);
      chk_cap("t10_b0", 0, 10'h2DE);
      chk_cap("t10_b3", 3, 10'h1EF);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d", pass_cnt, total_cnt);
      $fatal(1);
   end
endmodule
